// File: rtl/pipe_controller.sv
// pipe_controller: RV32I control decode for a 5-stage pipeline, plus the
// control-side D->E, E->M and M->W registers and Execute-stage branch resolve.
// Decode is purely combinational on op/funct3/funct7b5; everything downstream
// is registered with a synchronous active-low reset.
// Build macro PIPE_CTRL_ILLEGAL_EN adds the IllegalW output and suppresses
// register/memory writes for encodings that are not legal RV32I.
module pipe_controller #(
    parameter int ALUCTRL_W   = 4,
    parameter int RESULTSRC_W = 2,
    parameter int IMMSRC_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             op,
    input  logic [2:0]             funct3,
    input  logic                   funct7b5,
    input  logic                   StallE,
    input  logic                   FlushE,
    input  logic                   ZeroE,
    input  logic                   LtE,
    input  logic                   LtuE,
    output logic [IMMSRC_W-1:0]    ImmSrcD,
    output logic                   ALUSrcAE,
    output logic                   ALUSrcBE,
    output logic [ALUCTRL_W-1:0]   ALUControlE,
    output logic                   ResultSrcE0,
    output logic                   PCSrcE,
    output logic                   PCTgtSrcE,
    output logic                   RegWriteM,
    output logic                   MemWriteM,
    output logic [2:0]             Funct3M,
    output logic                   RegWriteW,
    output logic [RESULTSRC_W-1:0] ResultSrcW
`ifdef PIPE_CTRL_ILLEGAL_EN
    ,
    output logic                   IllegalW
`endif
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Execute-stage control word; an all-zero word is a bubble.
    typedef struct packed {
        logic                   reg_write;
        logic [RESULTSRC_W-1:0] result_src;
        logic                   mem_write;
        logic                   jump;
        logic                   branch;
        logic                   jalr;
        logic                   alu_src_a;
        logic                   alu_src_b;
        logic [ALUCTRL_W-1:0]   alu_ctrl;
        logic [2:0]             funct3;
`ifdef PIPE_CTRL_ILLEGAL_EN
        logic                   illegal;
`endif
    } ctrl_e_t;

    typedef struct packed {
        logic                   reg_write;
        logic [RESULTSRC_W-1:0] result_src;
        logic                   mem_write;
        logic [2:0]             funct3;
`ifdef PIPE_CTRL_ILLEGAL_EN
        logic                   illegal;
`endif
    } ctrl_m_t;

    typedef struct packed {
        logic                   reg_write;
        logic [RESULTSRC_W-1:0] result_src;
`ifdef PIPE_CTRL_ILLEGAL_EN
        logic                   illegal;
`endif
    } ctrl_w_t;

    ctrl_e_t    dec;
    logic [2:0] imm_src;
    logic [3:0] alu_op;
    logic [1:0] res_src;
    logic       supported;
    logic       funct7_ok;

    ctrl_e_t ctrl_e_d, ctrl_e_q;
    ctrl_m_t ctrl_m_d, ctrl_m_q;
    ctrl_w_t ctrl_w_d, ctrl_w_q;

    logic taken;

    // Arithmetic ops shared by op and op-imm; sub only exists in register form.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                   input logic       f7b5,
                                                   input logic       is_reg);
        logic [3:0] r;
        case (f3)
            3'b000:  r = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    // Decode: unsupported opcodes fall through with an all-zero control word.
    always_comb begin
        dec       = '0;
        imm_src   = IMM_I;
        alu_op    = ALU_ADD;
        res_src   = RES_ALU;
        supported = 1'b1;
        funct7_ok = 1'b1;
        case (op)
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = 1'b1;
                imm_src       = IMM_U;
                alu_op        = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                imm_src       = IMM_U;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                imm_src       = IMM_J;
                res_src       = RES_PC4;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.jalr      = 1'b1;
                dec.alu_src_b = 1'b1;
                res_src       = RES_PC4;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                imm_src    = IMM_B;
                alu_op     = ALU_SUB;
            end
            OP_LOAD: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = 1'b1;
                res_src       = RES_MEM;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = 1'b1;
                imm_src       = IMM_S;
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = 1'b1;
                alu_op        = alu_from_funct3(funct3, funct7b5, 1'b0);
                // instr[30] is ordinary immediate data except on shifts
                funct7_ok     = !(funct7b5 && funct3 == 3'b001);
            end
            OP_REG: begin
                dec.reg_write = 1'b1;
                alu_op        = alu_from_funct3(funct3, funct7b5, 1'b1);
                funct7_ok     = !funct7b5 || funct3 == 3'b000 || funct3 == 3'b101;
            end
            default: supported = 1'b0;
        endcase
        if (supported) begin
            dec.funct3 = funct3;
        end
        dec.result_src = RESULTSRC_W'(res_src);
        dec.alu_ctrl   = ALUCTRL_W'(alu_op);
`ifdef PIPE_CTRL_ILLEGAL_EN
        dec.illegal = !supported || !funct7_ok;
        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_write = 1'b0;
        end
`endif
    end

    assign ImmSrcD = IMMSRC_W'(imm_src);

    // D->E: flush loads a bubble and wins over stall; stall holds.
    always_comb begin
        ctrl_e_d = ctrl_e_q;
        if (FlushE) begin
            ctrl_e_d = '0;
        end else if (!StallE) begin
            ctrl_e_d = dec;
        end
    end

    // E->M: a held E instruction sends a bubble so it reaches M only once.
    always_comb begin
        ctrl_m_d.reg_write  = ctrl_e_q.reg_write;
        ctrl_m_d.result_src = ctrl_e_q.result_src;
        ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
        ctrl_m_d.funct3     = ctrl_e_q.funct3;
`ifdef PIPE_CTRL_ILLEGAL_EN
        ctrl_m_d.illegal    = ctrl_e_q.illegal;
`endif
        if (StallE && !FlushE) begin
            ctrl_m_d = '0;
        end
    end

    // M->W: always advances.
    always_comb begin
        ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
        ctrl_w_d.result_src = ctrl_m_q.result_src;
`ifdef PIPE_CTRL_ILLEGAL_EN
        ctrl_w_d.illegal    = ctrl_m_q.illegal;
`endif
    end

    // Pipeline control registers with synchronous reset discarding in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_e_q <= '0;
            ctrl_m_q <= '0;
            ctrl_w_q <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            ctrl_m_q <= ctrl_m_d;
            ctrl_w_q <= ctrl_w_d;
        end
    end

    // Branch condition from the registered funct3 and ALU flags.
    always_comb begin
        taken = 1'b0;
        case (ctrl_e_q.funct3)
            3'b000:  taken = ZeroE;
            3'b001:  taken = !ZeroE;
            3'b100:  taken = LtE;
            3'b101:  taken = !LtE;
            3'b110:  taken = LtuE;
            3'b111:  taken = !LtuE;
            default: taken = 1'b0;
        endcase
    end

    // A bubble has branch/jump clear, so it can never redirect fetch.
    assign PCSrcE      = (ctrl_e_q.branch && taken) || ctrl_e_q.jump;
    assign PCTgtSrcE   = ctrl_e_q.jalr;
    assign ALUSrcAE    = ctrl_e_q.alu_src_a;
    assign ALUSrcBE    = ctrl_e_q.alu_src_b;
    assign ALUControlE = ctrl_e_q.alu_ctrl;
    assign ResultSrcE0 = ctrl_e_q.result_src[0];
    assign RegWriteM   = ctrl_m_q.reg_write;
    assign MemWriteM   = ctrl_m_q.mem_write;
    assign Funct3M     = ctrl_m_q.funct3;
    assign RegWriteW   = ctrl_w_q.reg_write;
    assign ResultSrcW  = ctrl_w_q.result_src;
`ifdef PIPE_CTRL_ILLEGAL_EN
    assign IllegalW    = ctrl_w_q.illegal;
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Directed testbench for pipe_controller: decode, branch resolve, pipeline
// latency, stall/flush behaviour and mid-pipeline reset.
module tb_pipe_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       StallE, FlushE, ZeroE, LtE, LtuE;
    logic [2:0] ImmSrcD;
    logic       ALUSrcAE, ALUSrcBE;
    logic [3:0] ALUControlE;
    logic       ResultSrcE0, PCSrcE, PCTgtSrcE;
    logic       RegWriteM, MemWriteM;
    logic [2:0] Funct3M;
    logic       RegWriteW;
    logic [1:0] ResultSrcW;
`ifdef PIPE_CTRL_ILLEGAL_EN
    logic       IllegalW;
`endif

    int checks = 0;
    int fails  = 0;

    pipe_controller #(.ALUCTRL_W(4), .RESULTSRC_W(2), .IMMSRC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(ImmSrcD), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .ALUControlE(ALUControlE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .PCTgtSrcE(PCTgtSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
`ifdef PIPE_CTRL_ILLEGAL_EN
        , .IllegalW(IllegalW)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic set_nop();
        set_instr(7'b0000000, 3'b000, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; StallE = 0; FlushE = 0; ZeroE = 0; LtE = 0; LtuE = 0;
        set_instr(7'b0110111, 3'b000, 1'b0);
        tick(); tick();
        checks++; if (ImmSrcD !== 3'b100) begin fails++; $display("FAIL reset_immsrc_d got %b want 100", ImmSrcD); end
        checks++; if (ALUControlE !== 4'd0 || ALUSrcBE !== 1'b0) begin fails++; $display("FAIL reset_e got alu=%b srcb=%b want 0", ALUControlE, ALUSrcBE); end
        checks++; if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || RegWriteW !== 1'b0 || ResultSrcW !== 2'b00) begin
            fails++; $display("FAIL reset_mw got rwm=%b mwm=%b rww=%b rsw=%b want 0", RegWriteM, MemWriteM, RegWriteW, ResultSrcW);
        end
        rst_n = 1'b1;
        set_nop();
        tick();
    endtask

    task automatic test_sub_latency();
        set_instr(7'b0110011, 3'b000, 1'b1);
        tick(); set_nop();
        checks++; if (ALUControlE !== 4'b0001) begin fails++; $display("FAIL sub_alu_e got %b want 0001", ALUControlE); end
        tick();
        checks++; if (RegWriteM !== 1'b1) begin fails++; $display("FAIL sub_regwrite_m got %b want 1", RegWriteM); end
        tick();
        checks++; if (RegWriteW !== 1'b1 || ResultSrcW !== 2'b00) begin fails++; $display("FAIL sub_w got rw=%b rs=%b want 1 00", RegWriteW, ResultSrcW); end
        tick();
        checks++; if (RegWriteW !== 1'b0) begin fails++; $display("FAIL sub_w_drain got %b want 0", RegWriteW); end
    endtask

    // {op[6:0], funct3, f7b5, imm[2:0], alu[3:0], srcA, srcB}
    logic [19:0] dvec [9];

    task automatic test_decode();
        dvec[0] = {7'b0110111, 3'b000, 1'b0, 3'b100, 4'b1010, 1'b0, 1'b1}; // lui
        dvec[1] = {7'b0010111, 3'b000, 1'b0, 3'b100, 4'b0000, 1'b1, 1'b1}; // auipc
        dvec[2] = {7'b0010011, 3'b101, 1'b1, 3'b000, 4'b1001, 1'b0, 1'b1}; // srai
        dvec[3] = {7'b0110011, 3'b101, 1'b0, 3'b000, 4'b1000, 1'b0, 1'b0}; // srl
        dvec[4] = {7'b0110011, 3'b011, 1'b0, 3'b000, 4'b0110, 1'b0, 1'b0}; // sltu
        dvec[5] = {7'b0110011, 3'b111, 1'b0, 3'b000, 4'b0010, 1'b0, 1'b0}; // and
        dvec[6] = {7'b0100011, 3'b010, 1'b0, 3'b001, 4'b0000, 1'b0, 1'b1}; // sw
        dvec[7] = {7'b1101111, 3'b000, 1'b0, 3'b011, 4'b0000, 1'b0, 1'b0}; // jal
        dvec[8] = {7'b0010011, 3'b100, 1'b1, 3'b000, 4'b0100, 1'b0, 1'b1}; // xori
        for (int i = 0; i < 9; i++) begin
            logic [19:0] v;
            v = dvec[i];
            set_instr(v[19:13], v[12:10], v[9]);
            #1;
            checks++; if (ImmSrcD !== v[8:6]) begin fails++; $display("FAIL dec%0d_immsrc got %b want %b", i, ImmSrcD, v[8:6]); end
            tick(); set_nop();
            checks++; if (ALUControlE !== v[5:2] || ALUSrcAE !== v[1] || ALUSrcBE !== v[0]) begin
                fails++; $display("FAIL dec%0d_e got alu=%b a=%b b=%b want %b %b %b", i, ALUControlE, ALUSrcAE, ALUSrcBE, v[5:2], v[1], v[0]);
            end
        end
        tick();
    endtask

    // {funct3, zero, lt, ltu, expected PCSrcE}
    logic [6:0] bvec [7];

    task automatic test_branch();
        bvec[0] = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1}; // beq taken
        bvec[1] = {3'b000, 1'b0, 1'b1, 1'b1, 1'b0}; // beq not taken
        bvec[2] = {3'b001, 1'b1, 1'b0, 1'b0, 1'b0}; // bne not taken
        bvec[3] = {3'b110, 1'b0, 1'b0, 1'b1, 1'b1}; // bltu taken
        bvec[4] = {3'b101, 1'b0, 1'b1, 1'b0, 1'b0}; // bge not taken
        bvec[5] = {3'b111, 1'b0, 1'b1, 1'b0, 1'b1}; // bgeu taken
        bvec[6] = {3'b010, 1'b1, 1'b1, 1'b1, 1'b0}; // reserved funct3
        for (int i = 0; i < 7; i++) begin
            logic [6:0] v;
            v = bvec[i];
            ZeroE = 0; LtE = 0; LtuE = 0;
            set_instr(7'b1100011, v[6:4], 1'b0);
            tick(); set_nop();
            ZeroE = v[3]; LtE = v[2]; LtuE = v[1];
            #1;
            checks++; if (PCSrcE !== v[0] || PCTgtSrcE !== 1'b0 || ALUControlE !== 4'b0001) begin
                fails++; $display("FAIL br%0d got pcsrc=%b tgt=%b alu=%b want %b 0 0001", i, PCSrcE, PCTgtSrcE, ALUControlE, v[0]);
            end
        end
        ZeroE = 1; LtE = 1; LtuE = 1;
        tick();
        checks++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL br_bubble got %b want 0", PCSrcE); end
        ZeroE = 0; LtE = 0; LtuE = 0;
    endtask

    task automatic test_jump();
        set_instr(7'b1100111, 3'b000, 1'b0);
        tick(); set_nop();
        checks++; if (PCSrcE !== 1'b1 || PCTgtSrcE !== 1'b1 || ALUSrcBE !== 1'b1) begin
            fails++; $display("FAIL jalr_e got pcsrc=%b tgt=%b srcb=%b want 1 1 1", PCSrcE, PCTgtSrcE, ALUSrcBE);
        end
        tick(); tick();
        checks++; if (ResultSrcW !== 2'b10 || RegWriteW !== 1'b1) begin fails++; $display("FAIL jalr_w got rs=%b rw=%b want 10 1", ResultSrcW, RegWriteW); end
        set_instr(7'b1101111, 3'b000, 1'b0);
        tick(); set_nop();
        checks++; if (PCSrcE !== 1'b1 || PCTgtSrcE !== 1'b0) begin fails++; $display("FAIL jal_e got pcsrc=%b tgt=%b want 1 0", PCSrcE, PCTgtSrcE); end
        tick();
    endtask

    task automatic test_stall_flush();
        int writes;
        set_instr(7'b0100011, 3'b010, 1'b0);
        tick(); set_nop();
        StallE = 1;
        writes = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (MemWriteM === 1'b1) begin
                writes++;
                checks++; if (Funct3M !== 3'b010) begin fails++; $display("FAIL sw_funct3_m got %b want 010", Funct3M); end
            end
            if (i == 1) begin
                checks++; if (ALUSrcBE !== 1'b1) begin fails++; $display("FAIL sw_hold_e got srcb=%b want 1", ALUSrcBE); end
                StallE = 0;
            end
        end
        checks++; if (writes != 1) begin fails++; $display("FAIL sw_memwrite_count got %0d want 1", writes); end

        set_instr(7'b1100011, 3'b000, 1'b0);
        tick(); set_nop();
        StallE = 1; FlushE = 1; ZeroE = 1;
        #1;
        checks++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL flush_pre got %b want 1", PCSrcE); end
        tick();
        checks++; if (PCSrcE !== 1'b0 || ALUControlE !== 4'd0) begin fails++; $display("FAIL flush_bubble got pcsrc=%b alu=%b want 0 0000", PCSrcE, ALUControlE); end
        StallE = 0; FlushE = 0; ZeroE = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_instr(7'b0000011, 3'b010, 1'b0);
        tick(); set_nop();
        checks++; if (ResultSrcE0 !== 1'b1) begin fails++; $display("FAIL lw_resultsrc_e0 got %b want 1", ResultSrcE0); end
        tick();
        checks++; if (RegWriteM !== 1'b1) begin fails++; $display("FAIL lw_regwrite_m got %b want 1", RegWriteM); end
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (RegWriteW !== 1'b0 || ResultSrcW !== 2'b00) begin
                fails++; $display("FAIL rst_mid%0d got rw=%b rs=%b want 0 00", i, RegWriteW, ResultSrcW);
            end
            tick();
        end
    endtask

`ifdef PIPE_CTRL_ILLEGAL_EN
    task automatic test_illegal();
        set_instr(7'b0110011, 3'b001, 1'b1);
        tick(); set_nop(); tick(); tick();
        checks++; if (IllegalW !== 1'b1 || RegWriteW !== 1'b0) begin fails++; $display("FAIL illegal_f7 got ill=%b rw=%b want 1 0", IllegalW, RegWriteW); end
        set_instr(7'b0110011, 3'b101, 1'b1);
        tick(); set_nop(); tick(); tick();
        checks++; if (IllegalW !== 1'b0 || RegWriteW !== 1'b1) begin fails++; $display("FAIL illegal_sra got ill=%b rw=%b want 0 1", IllegalW, RegWriteW); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; StallE = 0; FlushE = 0; ZeroE = 0; LtE = 0; LtuE = 0;
        set_nop();
        test_reset();
        test_sub_latency();
        test_decode();
        test_branch();
        test_jump();
        test_stall_flush();
        test_reset_mid();
`ifdef PIPE_CTRL_ILLEGAL_EN
        test_illegal();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
